// File: rtl/cook_cycle_sequencer.sv
// ============================================================================
// cook_cycle_sequencer : microwave cook-cycle FSM, MM:SS BCD countdown, door
// interlock, end beep. Optional feature macro: QUICK_START_EN. Rev 1.0
// ============================================================================
`default_nettype none

module cook_cycle_sequencer #(
    parameter int TICK_DIV    = 100,
    parameter int BEEP_CYCLES = 8
`ifdef QUICK_START_EN
    ,
    parameter int QUICK_SEC   = 30
`endif
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        startn,
    input  logic        stopn,
    input  logic        clearn,
    input  logic        door_closed,
    input  logic        key_valid,
    input  logic [3:0]  key_digit,
    output logic        mag_on,
    output logic        timer_done,
    output logic        beep,
    output logic [2:0]  state,
    output logic [15:0] time_bcd
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ENTRY = 3'd1,
        S_COOK  = 3'd2,
        S_PAUSE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam int PW = $clog2(TICK_DIV + 1);
    localparam int BW = $clog2(BEEP_CYCLES + 1);
    localparam logic [PW-1:0] c_TICK_LAST = PW'(TICK_DIV - 1);
    localparam logic [BW-1:0] c_BEEP_LAST = BW'(BEEP_CYCLES - 1);

    state_t         state_q, state_d;
    logic [15:0]    time_q, time_d;
    logic [PW-1:0]  presc_q, presc_d;
    logic [BW-1:0]  beep_cnt_q, beep_cnt_d;
    logic           done_q, done_d;
    logic           startn_q, stopn_q, clearn_q;

    logic           w_clear, w_stop, w_start, w_can_start;

    // Falling edge against the previous sample; lower-priority buttons are masked.
    assign w_clear     = clearn_q & ~clearn;
    assign w_stop      = stopn_q & ~stopn & ~w_clear;
    assign w_start     = startn_q & ~startn & ~w_clear & ~(stopn_q & ~stopn);
    assign w_can_start = (time_q != 16'h0000) && door_closed;

    function automatic logic [15:0] bcd_dec(input logic [15:0] t);
        logic [15:0] r;
        r = t;
        if (t[3:0] != 4'd0) begin
            r[3:0] = t[3:0] - 4'd1;
        end else if (t[7:4] != 4'd0) begin
            r[7:4] = t[7:4] - 4'd1;
            r[3:0] = 4'd9;
        end else begin
            r[7:0] = 8'h59;
            if (t[11:8] != 4'd0) begin
                r[11:8] = t[11:8] - 4'd1;
            end else begin
                r[11:8]  = 4'd9;
                r[15:12] = t[15:12] - 4'd1;
            end
        end
        return r;
    endfunction

`ifdef QUICK_START_EN
    localparam int QMIN = QUICK_SEC / 60;
    localparam int QSEC = QUICK_SEC % 60;
    localparam logic [15:0] c_QUICK_BCD = {4'(QMIN / 10), 4'(QMIN % 10),
                                           4'(QSEC / 10), 4'(QSEC % 10)};

    // Digit-wise BCD add of the quick-start time, saturating at 99:59.
    function automatic logic [15:0] bcd_add_quick(input logic [15:0] t);
        logic [4:0] s1, s10, m1, m10;
        logic       c;
        s1  = {1'b0, t[3:0]} + {1'b0, c_QUICK_BCD[3:0]};
        c   = (s1 >= 5'd10);
        if (c) s1 = s1 - 5'd10;
        s10 = {1'b0, t[7:4]} + {1'b0, c_QUICK_BCD[7:4]} + {4'd0, c};
        c   = (s10 >= 5'd6);
        if (c) s10 = s10 - 5'd6;
        m1  = {1'b0, t[11:8]} + {1'b0, c_QUICK_BCD[11:8]} + {4'd0, c};
        c   = (m1 >= 5'd10);
        if (c) m1 = m1 - 5'd10;
        m10 = {1'b0, t[15:12]} + {1'b0, c_QUICK_BCD[15:12]} + {4'd0, c};
        if (m10 >= 5'd10) return 16'h9959;
        return {m10[3:0], m1[3:0], s10[3:0], s1[3:0]};
    endfunction
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= S_IDLE;
            time_q     <= 16'h0000;
            presc_q    <= '0;
            beep_cnt_q <= '0;
            done_q     <= 1'b0;
            startn_q   <= 1'b1;
            stopn_q    <= 1'b1;
            clearn_q   <= 1'b1;
        end else begin
            state_q    <= state_d;
            time_q     <= time_d;
            presc_q    <= presc_d;
            beep_cnt_q <= beep_cnt_d;
            done_q     <= done_d;
            startn_q   <= startn;
            stopn_q    <= stopn;
            clearn_q   <= clearn;
        end
    end

    always_comb begin
        state_d    = state_q;
        time_d     = time_q;
        presc_d    = presc_q;
        beep_cnt_d = '0;
        done_d     = 1'b0;
        case (state_q)
            S_IDLE, S_ENTRY: begin
                if (w_clear) begin
                    state_d = S_IDLE;
                    time_d  = 16'h0000;
                end else if (w_start && w_can_start) begin
                    state_d = S_COOK;
                    presc_d = '0;
`ifdef QUICK_START_EN
                end else if (w_start && state_q == S_IDLE &&
                             time_q == 16'h0000 && door_closed) begin
                    state_d = S_COOK;
                    time_d  = c_QUICK_BCD;
                    presc_d = '0;
`endif
                end else if (key_valid && key_digit <= 4'd9) begin
                    state_d = S_ENTRY;
                    time_d  = {time_q[11:0], key_digit};
                end
            end
            S_COOK: begin
                if (w_clear) begin
                    state_d = S_IDLE;
                    time_d  = 16'h0000;
                end else if (!door_closed || w_stop) begin
                    state_d = S_PAUSE;
                end else begin
`ifdef QUICK_START_EN
                    if (w_start) time_d = bcd_add_quick(time_q);
                    else
`endif
                    if (presc_q == c_TICK_LAST) begin
                        presc_d = '0;
                        time_d  = bcd_dec(time_q);
                        if (bcd_dec(time_q) == 16'h0000) begin
                            state_d = S_DONE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        presc_d = presc_q + PW'(1);
                    end
                end
            end
            S_PAUSE: begin
                if (w_clear || w_stop) begin
                    state_d = S_IDLE;
                    time_d  = 16'h0000;
                end else if (w_start && w_can_start) begin
                    state_d = S_COOK;
                    presc_d = '0;
                end
            end
            S_DONE: begin
                if (w_clear || w_stop || w_start) begin
                    state_d = S_IDLE;
                    time_d  = 16'h0000;
                end else if (beep_cnt_q == c_BEEP_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    beep_cnt_d = beep_cnt_q + BW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                time_d  = 16'h0000;
            end
        endcase
    end

    assign mag_on     = (state_q == S_COOK) & door_closed;
    assign timer_done = done_q;
    assign beep       = (state_q == S_DONE);
    assign state      = state_q;
    assign time_bcd   = time_q;

endmodule

`default_nettype wire

// File: tb/tb_cook_cycle_sequencer.sv
// ============================================================================
// tb_cook_cycle_sequencer : directed self-checking bench for the cook-cycle
// sequencer (entry, countdown, borrow, door interlock, buttons, reset). Rev 1.0
// ============================================================================
`default_nettype none

module tb_cook_cycle_sequencer;

    logic        clk = 1'b0;
    logic        rstn;
    logic        startn, stopn, clearn, door_closed, key_valid;
    logic [3:0]  key_digit;
    logic        mag_on, timer_done, beep;
    logic [2:0]  state;
    logic [15:0] time_bcd;

    int n_chk  = 0;
    int n_pass = 0;

    cook_cycle_sequencer dut (
        .clk         (clk),
        .rstn        (rstn),
        .startn      (startn),
        .stopn       (stopn),
        .clearn      (clearn),
        .door_closed (door_closed),
        .key_valid   (key_valid),
        .key_digit   (key_digit),
        .mag_on      (mag_on),
        .timer_done  (timer_done),
        .beep        (beep),
        .state       (state),
        .time_bcd    (time_bcd)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic key(input logic [3:0] d);
        key_digit = d;
        key_valid = 1'b1;
        step(1);
        key_valid = 1'b0;
    endtask

    // 0 = start, 1 = stop, 2 = clear; one-cycle press, released afterwards
    task automatic press(input int which);
        if (which == 0) startn = 1'b0;
        if (which == 1) stopn  = 1'b0;
        if (which == 2) clearn = 1'b0;
        step(1);
        startn = 1'b1;
        stopn  = 1'b1;
        clearn = 1'b1;
    endtask

    initial begin
        rstn = 1'b0; startn = 1'b1; stopn = 1'b1; clearn = 1'b1;
        door_closed = 1'b1; key_valid = 1'b0; key_digit = 4'd0;
        step(3);
        chk("rst_state", state, 0);
        chk("rst_time", time_bcd, 16'h0000);
        chk("rst_mag", mag_on, 0);
        chk("rst_done", timer_done, 0);
        chk("rst_beep", beep, 0);
        rstn = 1'b1;
        step(1);

        // 01:30 full cycle
        key(4'd1); key(4'd3); key(4'd0);
        chk("t1_entry_time", time_bcd, 16'h0130);
        chk("t1_entry_state", state, 1);
        press(0);
        chk("t1_cook_state", state, 2);
        chk("t1_cook_mag", mag_on, 1);
        chk("t1_cook_time", time_bcd, 16'h0130);
        step(100);
        chk("t1_tick1", time_bcd, 16'h0129);
        step(8899);
        chk("t1_last_sec", time_bcd, 16'h0001);
        chk("t1_no_done_yet", timer_done, 0);
        step(1);
        chk("t1_done_state", state, 4);
        chk("t1_done_pulse", timer_done, 1);
        chk("t1_done_time", time_bcd, 16'h0000);
        chk("t1_done_mag", mag_on, 0);
        chk("t1_beep_on", beep, 1);
        step(1);
        chk("t1_pulse_1cyc", timer_done, 0);
        step(6);
        chk("t1_beep_8th", beep, 1);
        step(1);
        chk("t1_idle", state, 0);
        chk("t1_beep_off", beep, 0);

        // 01:00 minute borrow
        key(4'd1); key(4'd0); key(4'd0);
        chk("t2_entry", time_bcd, 16'h0100);
        press(0);
        step(100);
        chk("t2_borrow", time_bcd, 16'h0059);
        step(5899);
        chk("t2_last_sec", time_bcd, 16'h0001);
        step(1);
        chk("t2_done_state", state, 4);
        chk("t2_done_pulse", timer_done, 1);
        press(2);
        chk("t2_btn_exit_done", state, 0);

        // door interlock at 00:10, bad keys ignored
        key(4'd1); key(4'd0); key(4'd12);
        chk("t3_bad_key", time_bcd, 16'h0010);
        press(0);
        chk("t3_cook", state, 2);
        step(50);
        key(4'd7);
        chk("t3_key_in_cook", time_bcd, 16'h0010);
        door_closed = 1'b0;
        #1;
        chk("t3_mag_drop", mag_on, 0);
        chk("t3_still_cook", state, 2);
        step(1);
        chk("t3_pause", state, 3);
        chk("t3_held", time_bcd, 16'h0010);
        press(0);
        chk("t3_start_door_open", state, 3);
        door_closed = 1'b1;
        step(1);
        press(0);
        chk("t3_resume", state, 2);
        chk("t3_resume_mag", mag_on, 1);
        chk("t3_resume_time", time_bcd, 16'h0010);

        // stop+start together, held buttons, clear+start
        stopn = 1'b0; startn = 1'b0;
        step(1);
        chk("t4_stop_wins", state, 3);
        step(3);
        chk("t4_hold_no_repeat", state, 3);
        stopn = 1'b1; startn = 1'b1;
        step(1);
        clearn = 1'b0; startn = 1'b0;
        step(1);
        chk("t4_clear_wins", state, 0);
        chk("t4_clear_time", time_bcd, 16'h0000);
        clearn = 1'b1; startn = 1'b1;
        step(1);

        // start with zero time / door open
        press(0);
`ifdef QUICK_START_EN
        chk("t5_quick_state", state, 2);
        chk("t5_quick_time", time_bcd, 16'h0030);
        press(2);
`else
        chk("t5_zero_state", state, 0);
        chk("t5_zero_mag", mag_on, 0);
`endif
        key(4'd5);
        door_closed = 1'b0;
        press(0);
        chk("t5_door_open_state", state, 1);
        chk("t5_door_open_mag", mag_on, 0);
        door_closed = 1'b1;
        step(1);
        press(0);
        chk("t5_cook", state, 2);
        press(1);
        chk("t5_pause", state, 3);
        step(1);
        press(1);
        chk("t5_stop_pause_idle", state, 0);
        chk("t5_stop_pause_time", time_bcd, 16'h0000);

        // asynchronous reset mid-cook
        key(4'd2);
        press(0);
        step(30);
        chk("t6_cook_before_rst", mag_on, 1);
        #2 rstn = 1'b0;
        #1;
        chk("t6_mag", mag_on, 0);
        chk("t6_state", state, 0);
        chk("t6_time", time_bcd, 16'h0000);
        chk("t6_beep", beep, 0);
        chk("t6_done", timer_done, 0);
        step(2);
        rstn = 1'b1;
        step(1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
